// File: rtl/snake_ctrl.sv
// Snake game sequencer: divides clk into movement ticks, latches the player's
// direction, steps the snake, then acts on the collision checker's results.
module snake_ctrl #(
  parameter int unsigned TICK_DIV = 2500000,
  parameter int unsigned LEN_INIT = 2,
  parameter int unsigned LEN_MAX  = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       lose,
  input  logic       win,
  input  logic [5:0] points,
  input  logic       apple_ack,
  output logic       game_rst,
  output logic       move_en,
  output logic [1:0] dir,
  output logic       grow,
  output logic       apple_req,
  output logic [5:0] length,
  output logic [2:0] state,
  output logic       game_over,
  output logic       game_won
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [5:0] LEN_RST = 6'(LEN_INIT);
  localparam logic [5:0] LEN_SAT = 6'(LEN_MAX);
  localparam logic [5:0] PTS_RST = 6'd2;

  localparam logic [1:0] D_RIGHT = 2'b00;
  localparam logic [1:0] D_LEFT  = 2'b01;
  localparam logic [1:0] D_UP    = 2'b10;
  localparam logic [1:0] D_DOWN  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    MOVE    = 3'd2,
    CHECK   = 3'd3,
    RESPAWN = 3'd4,
    OVER    = 3'd5,
    WON     = 3'd6
  } state_t;

  state_t        st;
  logic [CW-1:0] tick_cnt;
  logic          chk_second;
  logic [1:0]    pend;
  logic [1:0]    pend_nxt;
  logic [5:0]    points_prev;

  assign state = st;

  // Reverse presses are skipped so a lower-priority button can still win.
  always_comb begin
    pend_nxt = pend;
    if (btn_up && dir != D_DOWN)
      pend_nxt = D_UP;
    else if (btn_down && dir != D_UP)
      pend_nxt = D_DOWN;
    else if (btn_left && dir != D_RIGHT)
      pend_nxt = D_LEFT;
    else if (btn_right && dir != D_LEFT)
      pend_nxt = D_RIGHT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      tick_cnt    <= '0;
      chk_second  <= 1'b0;
      pend        <= D_RIGHT;
      dir         <= D_RIGHT;
      points_prev <= PTS_RST;
      length      <= LEN_RST;
      game_rst    <= 1'b0;
      move_en     <= 1'b0;
      grow        <= 1'b0;
      apple_req   <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      game_rst <= 1'b0;
      move_en  <= 1'b0;
      grow     <= 1'b0;
      if (st inside {RUN, MOVE, CHECK, RESPAWN})
        pend <= pend_nxt;

      case (st)
        IDLE: begin
          if (start) begin
            game_rst    <= 1'b1;
            length      <= LEN_RST;
            dir         <= D_RIGHT;
            pend        <= D_RIGHT;
            points_prev <= PTS_RST;
            tick_cnt    <= '0;
            st          <= RUN;
          end
        end
        RUN: begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            st       <= MOVE;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        MOVE: begin
          move_en    <= 1'b1;
          dir        <= pend;
          chk_second <= 1'b0;
          st         <= CHECK;
        end
        CHECK: begin
          if (!chk_second) begin
            chk_second <= 1'b1;
          end else begin
            chk_second <= 1'b0;
            if (lose) begin
              game_over <= 1'b1;
              st        <= OVER;
            end else if (win) begin
              game_won <= 1'b1;
              st       <= WON;
            end else if (points != points_prev) begin
              grow        <= 1'b1;
              apple_req   <= 1'b1;
              length      <= (length >= LEN_SAT) ? LEN_SAT : length + 6'd1;
              points_prev <= points;
              st          <= RESPAWN;
            end else begin
              st <= RUN;
            end
          end
        end
        RESPAWN: begin
          if (apple_ack) begin
            apple_req <= 1'b0;
            st        <= RUN;
          end
        end
        OVER: begin
          if (start) begin
            game_over <= 1'b0;
            st        <= IDLE;
          end
        end
        WON: begin
          if (start) begin
            game_won <= 1'b0;
            st       <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: deadline-based game model checked every cycle, directed
// scenarios with literal expectations, then randomized play.
module tb_snake_ctrl;

  localparam int TDIV = 4;
  localparam int LINIT = 2;
  localparam int LMAX = 23;

  localparam int S_IDLE = 0, S_RUN = 1, S_MOVE = 2, S_CHECK = 3;
  localparam int S_RESPAWN = 4, S_OVER = 5, S_WON = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       lose = 1'b0, win = 1'b0;
  logic [5:0] points = 6'd2;
  logic       apple_ack = 1'b0;
  logic       game_rst, move_en, grow, apple_req, game_over, game_won;
  logic [1:0] dir;
  logic [5:0] length;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  snake_ctrl #(.TICK_DIV(TDIV), .LEN_INIT(LINIT), .LEN_MAX(LMAX)) dut (
    .clk(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .lose(lose), .win(win), .points(points), .apple_ack(apple_ack),
    .game_rst(game_rst), .move_en(move_en), .dir(dir), .grow(grow),
    .apple_req(apple_req), .length(length), .state(state),
    .game_over(game_over), .game_won(game_won)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: one state label plus a cycle deadline for timed states.
  int cyc = 0;
  int m_state, m_deadline, m_pend, m_dir, m_len, m_prev;
  int m_grst, m_move, m_grow, m_req, m_over, m_won;
  bit mdl_valid = 1'b0;

  function automatic int top_button(input logic u, input logic d, input logic l, input logic r);
    if (u) return 2;
    if (d) return 3;
    if (l) return 1;
    if (r) return 0;
    return -1;
  endfunction

  always @(posedge clk) begin
    int b, old_pend;
    cyc++;
    m_grst = 0; m_move = 0; m_grow = 0;
    if (reset) begin
      m_state = S_IDLE; m_deadline = 0; m_pend = 0; m_dir = 0;
      m_len = LINIT; m_prev = 2; m_req = 0; m_over = 0; m_won = 0;
      mdl_valid = 1'b1;
    end else begin
      old_pend = m_pend;
      if (m_state inside {S_RUN, S_MOVE, S_CHECK, S_RESPAWN}) begin
        b = top_button(btn_up, btn_down, btn_left, btn_right);
        if (b >= 0 && b != (m_dir ^ 1)) m_pend = b;
      end
      case (m_state)
        S_IDLE: if (start) begin
          m_grst = 1; m_len = LINIT; m_dir = 0; m_pend = 0; m_prev = 2;
          m_state = S_RUN; m_deadline = cyc + TDIV;
        end
        S_RUN: if (cyc == m_deadline) m_state = S_MOVE;
        S_MOVE: begin
          m_move = 1; m_dir = old_pend; m_state = S_CHECK; m_deadline = cyc + 2;
        end
        S_CHECK: if (cyc == m_deadline) begin
          if (lose) begin m_state = S_OVER; m_over = 1; end
          else if (win) begin m_state = S_WON; m_won = 1; end
          else if (int'(points) != m_prev) begin
            m_grow = 1; m_req = 1; m_prev = int'(points);
            m_len = (m_len + 1 > LMAX) ? LMAX : m_len + 1;
            m_state = S_RESPAWN;
          end else begin
            m_state = S_RUN; m_deadline = cyc + TDIV;
          end
        end
        S_RESPAWN: if (apple_ack) begin
          m_req = 0; m_state = S_RUN; m_deadline = cyc + TDIV;
        end
        S_OVER: if (start) begin m_over = 0; m_state = S_IDLE; end
        S_WON:  if (start) begin m_won = 0; m_state = S_IDLE; end
        default: m_state = S_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("state", int'(state), m_state);
      chk("game_rst", int'(game_rst), m_grst);
      chk("move_en", int'(move_en), m_move);
      chk("dir", int'(dir), m_dir);
      chk("grow", int'(grow), m_grow);
      chk("apple_req", int'(apple_req), m_req);
      chk("length", int'(length), m_len);
      chk("game_over", int'(game_over), m_over);
      chk("game_won", int'(game_won), m_won);
    end
  end

  task automatic wait_move(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (move_en !== 1'b1 && n < 100);
    chk("wait_move_seen", int'(move_en), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, req_cnt, pts, b;
    pts = 2;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), S_IDLE);
    chk("reset_length", int'(length), LINIT);
    reset = 1'b0;
    start = 1'b1;

    // Start timeline: game_rst at cycle 1, move_en at cycles 6, 13, 20.
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("start_game_rst", int'(game_rst), 1);
      end
      chk("tick_move_en", int'(move_en), (k == 6 || k == 13 || k == 20) ? 1 : 0);
      if (k == 20) begin
        chk("tick_dir", int'(dir), 0);
        chk("tick_length", int'(length), 2);
      end
    end

    btn_left = 1'b1;
    wait_move(n);
    btn_left = 1'b0;
    chk("reverse_left_ignored", int'(dir), 0);
    btn_up = 1'b1;
    wait_move(n);
    btn_up = 1'b0;
    chk("turn_up", int'(dir), 2);
    btn_down = 1'b1;
    wait_move(n);
    btn_down = 1'b0;
    chk("reverse_down_ignored", int'(dir), 2);

    // Eat once; apple_ack in the third apple_req cycle.
    pts = 3; points = 6'(pts);
    @(negedge clk);
    @(negedge clk);
    chk("eat_grow", int'(grow), 1);
    chk("eat_length", int'(length), 3);
    req_cnt = int'(apple_req);
    @(negedge clk);
    chk("eat_grow_single", int'(grow), 0);
    req_cnt += int'(apple_req);
    @(negedge clk);
    req_cnt += int'(apple_req);
    apple_ack = 1'b1;
    @(negedge clk);
    apple_ack = 1'b0;
    chk("eat_req_dropped", int'(apple_req), 0);
    chk("eat_req_cycles", req_cnt, 3);
    chk("eat_back_to_run", int'(state), S_RUN);
    wait_move(n);
    chk("eat_next_move_delay", n, TDIV + 1);

    // lose+win together with a points change.
    lose = 1'b1; win = 1'b1; pts = 4; points = 6'(pts);
    @(negedge clk);
    @(negedge clk);
    chk("lw_state", int'(state), S_OVER);
    chk("lw_over", int'(game_over), 1);
    chk("lw_won", int'(game_won), 0);
    chk("lw_length", int'(length), 3);
    lose = 1'b0; win = 1'b0; pts = 2; points = 6'(pts);
    start = 1'b1;
    @(negedge clk);
    chk("restart_idle", int'(state), S_IDLE);
    @(negedge clk);
    start = 1'b0;
    chk("restart_run", int'(state), S_RUN);
    chk("restart_game_rst", int'(game_rst), 1);

    // 25 apples with same-cycle ack: length must saturate.
    for (int e = 0; e < 25; e++) begin
      wait_move(n);
      pts = (pts + 1) % 64; points = 6'(pts);
      @(negedge clk);
      @(negedge clk);
      apple_ack = 1'b1;
      @(negedge clk);
      apple_ack = 1'b0;
    end
    chk("sat_length", int'(length), LMAX);
    wait_move(n);
    win = 1'b1;
    @(negedge clk);
    @(negedge clk);
    win = 1'b0;
    chk("won_state", int'(state), S_WON);
    chk("won_flag", int'(game_won), 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("won_no_move", int'(move_en), 0);
    end

    // Reset while waiting for an apple.
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    btn_up = 1'b1;
    wait_move(n);
    btn_up = 1'b0;
    chk("pre_reset_dir", int'(dir), 2);
    pts = (pts + 1) % 64; points = 6'(pts);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_req", int'(apple_req), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_resp_state", int'(state), S_IDLE);
    chk("rst_resp_req", int'(apple_req), 0);
    chk("rst_resp_length", int'(length), LINIT);
    chk("rst_resp_dir", int'(dir), 0);

    // Randomized play against the model.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 7) == 0);
      lose = ($urandom_range(0, 29) == 0);
      win = ($urandom_range(0, 59) == 0);
      apple_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) points = 6'($urandom_range(0, 63));
      btn_up = ($urandom_range(0, 5) == 0);
      btn_down = ($urandom_range(0, 5) == 0);
      btn_left = ($urandom_range(0, 5) == 0);
      btn_right = ($urandom_range(0, 5) == 0);
      b = top_button(btn_up, btn_down, btn_left, btn_right);
      if (b >= 0 && b == (m_dir ^ 1)) begin
        btn_up = (b == 2); btn_down = (b == 3); btn_left = (b == 1); btn_right = (b == 0);
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
